// File: rtl/hazard_scheduler_pkg.sv
// Shared types for the pipeline hazard scheduler: signal and register-address
// typedefs plus the scheduler FSM state encoding.
package hazard_scheduler_pkg;

  localparam int REG_AW_DEF = 5;

  typedef logic                  signal_t;
  typedef logic [REG_AW_DEF-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } sched_state_t;

endpackage

// File: rtl/hazard_scheduler_fwd_compare.sv
// Per-source hazard compare: X/M forwarding selects and the load-use match
// for one register source of the instruction leaving D.
module fwd_compare #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src_addr,
  input  logic          src_used,
  input  logic [AW-1:0] x_rd_addr,
  input  logic          x_reg_write,
  input  logic          x_mem_read,
  input  logic [AW-1:0] m_rd_addr,
  input  logic          m_reg_write,
  output logic          fwd_x,
  output logic          fwd_m,
  output logic          load_use
);

  logic x_hit;
  logic m_hit;

  // Register 0 is hard-wired, so it never participates in a hazard.
  assign x_hit    = src_used & x_reg_write & (x_rd_addr != '0) & (x_rd_addr == src_addr);
  assign m_hit    = src_used & m_reg_write & (m_rd_addr != '0) & (m_rd_addr == src_addr);

  assign fwd_x    = x_hit & ~x_mem_read;
  assign fwd_m    = m_hit & ~fwd_x;
  assign load_use = x_hit & x_mem_read;

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard controller: forwarding selects, load-use/branch bubbles,
// multi-cycle multiply stalls and data-memory wait freezes.
//
// state    | meaning
// RUN      | normal flow, hazards resolved combinationally
// MUL_BUSY | multiply occupying X, mul_cnt counts remaining stall cycles
// MEM_WAIT | data memory access in M not yet complete, pipeline frozen
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] d_rs_addr,
  input  logic [REG_AW-1:0] d_rt_addr,
  input  logic              d_uses_rs,
  input  logic              d_uses_rt,
  input  logic [REG_AW-1:0] x_rd_addr,
  input  logic              x_reg_write,
  input  logic              x_mem_read,
  input  logic              x_mul,
  input  logic              x_branch_taken,
  input  logic [REG_AW-1:0] m_rd_addr,
  input  logic              m_reg_write,
  input  logic              m_mem_access,
  input  logic              dmem_ready,
  output logic              fwdX_rs,
  output logic              fwdX_rt,
  output logic              fwdM_rs,
  output logic              fwdM_rt,
  output logic              bubble,
  output logic              stall_fd,
  output logic              stall_dx,
  output logic              xm_bubble,
  output logic              stall_all,
  output logic              flush_fd,
  output logic              busy
);

  localparam logic [2:0] MUL_LOAD = (MUL_LAT > 1) ? 3'(MUL_LAT - 2) : 3'd0;
  localparam logic       MUL_STALLS = (MUL_LAT > 1);

  sched_state_t state, state_nxt;
  logic [2:0]   mul_cnt, mul_cnt_nxt;

  logic fx_rs, fx_rt, fm_rs, fm_rt;
  logic lu_rs, lu_rt;
  logic mem_req;
  logic mul_stall;
  logic hazard_ok;

  fwd_compare #(.AW(REG_AW)) u_cmp_rs (
    .src_addr    (d_rs_addr),
    .src_used    (d_uses_rs),
    .x_rd_addr   (x_rd_addr),
    .x_reg_write (x_reg_write),
    .x_mem_read  (x_mem_read),
    .m_rd_addr   (m_rd_addr),
    .m_reg_write (m_reg_write),
    .fwd_x       (fx_rs),
    .fwd_m       (fm_rs),
    .load_use    (lu_rs)
  );

  fwd_compare #(.AW(REG_AW)) u_cmp_rt (
    .src_addr    (d_rt_addr),
    .src_used    (d_uses_rt),
    .x_rd_addr   (x_rd_addr),
    .x_reg_write (x_reg_write),
    .x_mem_read  (x_mem_read),
    .m_rd_addr   (m_rd_addr),
    .m_reg_write (m_reg_write),
    .fwd_x       (fx_rt),
    .fwd_m       (fm_rt),
    .load_use    (lu_rt)
  );

  assign mem_req = m_mem_access & ~dmem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      mul_cnt <= 3'd0;
    end else begin
      state   <= state_nxt;
      mul_cnt <= mul_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mul_cnt_nxt = mul_cnt;
    mul_stall   = 1'b0;
    hazard_ok   = 1'b0;
    stall_all   = 1'b0;
    bubble      = 1'b0;
    stall_fd    = 1'b0;
    stall_dx    = 1'b0;
    xm_bubble   = 1'b0;
    flush_fd    = 1'b0;

    case (state)
      RUN: begin
        if (mem_req) begin
          stall_all = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (x_mul && MUL_STALLS) begin
          mul_stall   = 1'b1;
          mul_cnt_nxt = MUL_LOAD;
          state_nxt   = MUL_BUSY;
        end else begin
          hazard_ok = 1'b1;
        end
      end
      MUL_BUSY: begin
        // A memory wait freezes the multiply count along with the pipeline.
        if (mem_req) begin
          stall_all = 1'b1;
        end else if (mul_cnt != 3'd0) begin
          mul_stall   = 1'b1;
          mul_cnt_nxt = mul_cnt - 3'd1;
        end else begin
          state_nxt = RUN;
          hazard_ok = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          stall_all = 1'b1;
        end else begin
          state_nxt = RUN;
          hazard_ok = 1'b1;
        end
      end
      default: begin
        state_nxt   = RUN;
        mul_cnt_nxt = 3'd0;
      end
    endcase

    if (mul_stall) begin
      stall_fd  = 1'b1;
      stall_dx  = 1'b1;
      xm_bubble = 1'b1;
    end else if (hazard_ok) begin
      if (x_branch_taken) begin
        flush_fd = 1'b1;
        bubble   = 1'b1;
      end else if (lu_rs || lu_rt) begin
        bubble   = 1'b1;
        stall_fd = 1'b1;
        stall_dx = 1'b1;
      end
    end

    if (!rst_n) begin
      stall_all = 1'b0;
      bubble    = 1'b0;
      stall_fd  = 1'b0;
      stall_dx  = 1'b0;
      xm_bubble = 1'b0;
      flush_fd  = 1'b0;
    end
  end

  assign fwdX_rs = rst_n & fx_rs;
  assign fwdX_rt = rst_n & fx_rt;
  assign fwdM_rs = rst_n & fm_rs;
  assign fwdM_rt = rst_n & fm_rt;
  assign busy    = rst_n & (state != RUN);

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed self-checking bench for hazard_scheduler (REG_AW=5, MUL_LAT=4).
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] d_rs_addr, d_rt_addr, x_rd_addr, m_rd_addr;
  logic       d_uses_rs, d_uses_rt;
  logic       x_reg_write, x_mem_read, x_mul, x_branch_taken;
  logic       m_reg_write, m_mem_access, dmem_ready;
  logic       fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt;
  logic       bubble, stall_fd, stall_dx, xm_bubble, stall_all, flush_fd, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_scheduler #(.REG_AW(5), .MUL_LAT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .d_rs_addr      (d_rs_addr),
    .d_rt_addr      (d_rt_addr),
    .d_uses_rs      (d_uses_rs),
    .d_uses_rt      (d_uses_rt),
    .x_rd_addr      (x_rd_addr),
    .x_reg_write    (x_reg_write),
    .x_mem_read     (x_mem_read),
    .x_mul          (x_mul),
    .x_branch_taken (x_branch_taken),
    .m_rd_addr      (m_rd_addr),
    .m_reg_write    (m_reg_write),
    .m_mem_access   (m_mem_access),
    .dmem_ready     (dmem_ready),
    .fwdX_rs        (fwdX_rs),
    .fwdX_rt        (fwdX_rt),
    .fwdM_rs        (fwdM_rs),
    .fwdM_rt        (fwdM_rt),
    .bubble         (bubble),
    .stall_fd       (stall_fd),
    .stall_dx       (stall_dx),
    .xm_bubble      (xm_bubble),
    .stall_all      (stall_all),
    .flush_fd       (flush_fd),
    .busy           (busy)
  );

  // Packed view of every output: {fwdX_rs,fwdX_rt,fwdM_rs,fwdM_rt,bubble,
  // stall_fd,stall_dx,xm_bubble,stall_all,flush_fd,busy}
  function automatic logic [10:0] outs();
    return {fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt, bubble,
            stall_fd, stall_dx, xm_bubble, stall_all, flush_fd, busy};
  endfunction

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    d_rs_addr = 5'd0; d_rt_addr = 5'd0; d_uses_rs = 1'b0; d_uses_rt = 1'b0;
    x_rd_addr = 5'd0; x_reg_write = 1'b0; x_mem_read = 1'b0; x_mul = 1'b0;
    x_branch_taken = 1'b0; m_rd_addr = 5'd0; m_reg_write = 1'b0;
    m_mem_access = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    // Forwarding match present while in reset: every output must stay 0.
    d_rs_addr = 5'd5; d_uses_rs = 1'b1; x_rd_addr = 5'd5; x_reg_write = 1'b1;
    sample();
    chk("reset_outputs", outs(), 11'b000_0000_0000);

    step(); rst_n = 1'b1;
    // X ALU writes r5, M also writes r5: X wins, no bubble.
    m_rd_addr = 5'd5; m_reg_write = 1'b1;
    sample();
    chk("fwd_x_rs", outs(), 11'b1000_0000_000);

    step(); x_rd_addr = 5'd0; m_rd_addr = 5'd0; d_rs_addr = 5'd0;
    sample();
    chk("fwd_r0_never", outs(), 11'b0000_0000_000);

    step(); idle(); d_rt_addr = 5'd9; d_uses_rt = 1'b1; m_rd_addr = 5'd9; m_reg_write = 1'b1;
    sample();
    chk("fwd_m_rt", outs(), 11'b0001_0000_000);

    step(); d_uses_rt = 1'b0;
    sample();
    chk("fwd_m_rt_unused", outs(), 11'b0000_0000_000);

    // Load-use: lw r7 in X, D reads rt=7.
    step(); idle(); x_rd_addr = 5'd7; x_reg_write = 1'b1; x_mem_read = 1'b1;
    d_rt_addr = 5'd7; d_uses_rt = 1'b1;
    sample();
    chk("load_use_c0", outs(), 11'b0000_1110_000);

    step(); x_rd_addr = 5'd0; x_reg_write = 1'b0; x_mem_read = 1'b0;
    m_rd_addr = 5'd7; m_reg_write = 1'b1;
    sample();
    chk("load_use_c1", outs(), 11'b0001_0000_000);

    // Multiply, MUL_LAT=4: stalls cycles 0-2, busy cycles 1-3.
    step(); idle(); x_mul = 1'b1;
    sample(); chk("mul_c0", outs(), 11'b0000_0111_000);
    step(); sample(); chk("mul_c1", outs(), 11'b0000_0111_001);
    step(); sample(); chk("mul_c2", outs(), 11'b0000_0111_001);
    step(); sample(); chk("mul_c3", outs(), 11'b0000_0000_001);
    step(); x_mul = 1'b0;
    sample(); chk("mul_c4", outs(), 11'b0000_0000_000);

    // Memory wait, 3 cycles, branch present but suppressed by stall_all.
    step(); idle(); m_mem_access = 1'b1; dmem_ready = 1'b0; x_branch_taken = 1'b1;
    sample(); chk("memw_c0", outs(), 11'b0000_0000_100);
    step(); sample(); chk("memw_c1", outs(), 11'b0000_0000_101);
    step(); sample(); chk("memw_c2", outs(), 11'b0000_0000_101);
    step(); dmem_ready = 1'b1; x_branch_taken = 1'b0;
    sample(); chk("memw_c3", outs(), 11'b0000_0000_001);
    step(); m_mem_access = 1'b0;
    sample(); chk("memw_c4", outs(), 11'b0000_0000_000);

    // Branch overrides a simultaneous load-use.
    step(); idle(); x_branch_taken = 1'b1; x_mem_read = 1'b1; x_reg_write = 1'b1;
    x_rd_addr = 5'd3; d_rs_addr = 5'd3; d_uses_rs = 1'b1;
    sample(); chk("branch_over_lu", outs(), 11'b0000_1000_010);

    // Memory wait during MUL_BUSY freezes the multiply count.
    step(); idle(); x_mul = 1'b1;
    sample(); chk("mulmem_c0", outs(), 11'b0000_0111_000);
    step(); sample(); chk("mulmem_c1", outs(), 11'b0000_0111_001);
    step(); m_mem_access = 1'b1; dmem_ready = 1'b0;
    sample(); chk("mulmem_c2", outs(), 11'b0000_0000_101);
    step(); dmem_ready = 1'b1;
    sample(); chk("mulmem_c3", outs(), 11'b0000_0111_001);
    step(); m_mem_access = 1'b0;
    sample(); chk("mulmem_c4", outs(), 11'b0000_0000_001);
    step(); x_mul = 1'b0;
    sample(); chk("mulmem_c5", outs(), 11'b0000_0000_000);

    // Reset asserted mid-MUL_BUSY aborts at once.
    step(); x_mul = 1'b1;
    step(); sample(); chk("rstmul_pre", outs(), 11'b0000_0111_001);
    step(); rst_n = 1'b0;
    sample(); chk("rstmul_in_reset", outs(), 11'b0000_0000_000);
    step(); rst_n = 1'b1; x_mul = 1'b0;
    sample(); chk("rstmul_after1", outs(), 11'b0000_0000_000);
    step(); sample(); chk("rstmul_after2", outs(), 11'b0000_0000_000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_scheduler.md
# hazard_scheduler

Pipeline hazard controller for the five-stage core. It generates the D→X forwarding selects and the bubble consumed by the DX forwarding stage, and sequences pipeline stalls and flushes for load-use hazards, multi-cycle multiplies, data-memory wait states and taken branches. It sits beside the pipeline registers and drives their hold/flush enables.

## Interface
Parameters:
- REG_AW, 5, register address width
- MUL_LAT, 4, cycles a multiply occupies X (≥1; 1 means no stall)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- d_rs_addr, d_rt_addr  in  REG_AW  sources of the instruction leaving D
- d_uses_rs, d_uses_rt  in  1  source actually read
- x_rd_addr  in  REG_AW  destination of the instruction in X
- x_reg_write, x_mem_read, x_mul  in  1  X-stage instruction attributes
- x_branch_taken  in  1  branch resolved taken in X
- m_rd_addr  in  REG_AW  destination in M
- m_reg_write, m_mem_access  in  1  M-stage attributes
- dmem_ready  in  1  data memory completes the M access this cycle
- fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt  out  1  forwarding selects
- bubble  out  1  inject NOP into X
- stall_fd  out  1  hold PC and F/D register
- stall_dx  out  1  hold D/X register
- xm_bubble  out  1  inject NOP into X/M
- stall_all  out  1  freeze every pipeline register
- flush_fd  out  1  clear F/D register
- busy  out  1  state ≠ RUN

## Operation
- FSM states: RUN, MUL_BUSY, MEM_WAIT; 3-bit down-counter mul_cnt.
- Forwarding (combinational, all states): fwdX_rs = d_uses_rs & x_reg_write & !x_mem_read & x_rd_addr≠0 & x_rd_addr==d_rs_addr. fwdM_rs = d_uses_rs & m_reg_write & m_rd_addr≠0 & m_rd_addr==d_rs_addr & !fwdX_rs. The rt selects are identical, using rt. Register 0 is never forwarded.
- Priority, highest first: memory wait > multiply > branch > load-use.
- Memory wait: m_mem_access & !dmem_ready raises stall_all in the same cycle (combinational) and moves RUN→MEM_WAIT. In MEM_WAIT, stall_all = !dmem_ready; dmem_ready → RUN. While stall_all is high, every other stall/flush/bubble output is 0.
- Multiply: in RUN, x_mul & MUL_LAT>1 raises stall_fd, stall_dx, xm_bubble, loads mul_cnt=MUL_LAT-2, and moves to MUL_BUSY. In MUL_BUSY with mul_cnt≠0: same outputs, decrement. With mul_cnt==0: outputs released, →RUN. The multiply therefore occupies X for exactly MUL_LAT cycles. The release cycle cannot retrigger.
- Branch: x_branch_taken (RUN, no mul start) → flush_fd=1, bubble=1 for one cycle; no stall_fd. This overrides a simultaneous load-use.
- Load-use: x_mem_read & x_reg_write & x_rd_addr≠0 & matching a used source → bubble=1, stall_fd=1, stall_dx=1 for one cycle. The next cycle the load is in M and fwdM_* selects it.
- Reset: state=RUN, mul_cnt=0; all outputs 0 while rst_n low. Reset mid-MUL_BUSY or mid-MEM_WAIT aborts immediately.

## Timing
- Forwarding, load-use, branch and memory-wait outputs have zero cycles of latency from their inputs.
- Multiply stall outputs are high for MUL_LAT-1 consecutive cycles, starting in the cycle x_mul is first seen in RUN.
- A memory wait arriving during MUL_BUSY: stall_all dominates and mul_cnt freezes. Counting resumes when stall_all drops.
- busy is registered state decode: high from the cycle after entry until the cycle after exit.

## Structure
- The shared definitions package holds Signal, the REG_AW-derived register-address typedef and an enum sched_state_t {RUN, MUL_BUSY, MEM_WAIT}.
- One sub-module, fwd_compare, computes the X and M match for one source and is instantiated twice (rs, rt). The FSM and priority logic live in hazard_scheduler.

## Test plan
- X writes r5 (ALU), D reads rs=5 → fwdX_rs=1, no bubble. Same with x_rd_addr=0 → fwdX_rs=0.
- X is lw r7, D reads rt=7 → cycle 0: bubble=stall_fd=stall_dx=1. Cycle 1: fwdM_rt=1, no stall.
- x_mul=1, MUL_LAT=4 → stall_fd/stall_dx/xm_bubble high cycles 0–2, low cycle 3. busy high cycles 1–3.
- m_mem_access=1, dmem_ready low for 3 cycles → stall_all high exactly 3 cycles, all other outputs 0. Then RUN.
- x_branch_taken with a simultaneous load-use match → flush_fd=1, bubble=1, stall_fd=0.
- rst_n low during MUL_BUSY → outputs 0 immediately. After release, state RUN and no stall without new x_mul.
